// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, funct3 codes and lane helpers for the data-memory access controller
package dmem_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE, SW_WRITE} dmem_state_e;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  // Unlisted funct3 codes (011/110/111) fall through to a full word.
  function automatic logic [2:0] lane_size(input logic [2:0] f3);
    return f3 == F3_W ? 3'd4 : (f3 == F3_B || f3 == F3_BU) ? 3'd1 : (f3 == F3_H || f3 == F3_HU) ? 3'd2 : 3'd4;
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (lane_size(f3) == 3'd2 && off[0]) || (lane_size(f3) == 3'd4 && off != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte/halfword lane extract-and-extend for loads and lane merge for partial stores
//   word   : memory word read back
//   wdata  : LSB-aligned store data
//   off    : byte offset within the word
//   funct3 : access size and signedness
//   ldata  : extended load result
//   mdata  : word with the store lane merged in
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);
  logic [2:0] sz;
  logic [4:0] sh;
  logic [31:0] lane, mask;
  always_comb begin
    sz = lane_size(funct3);
    sh = {off, 3'b000};
    lane = word >> sh;
    mask = (sz == 3'd1 ? 32'h0000_00FF : sz == 3'd2 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
    // funct3[2] marks the unsigned load variants
    ldata = sz == 3'd1 ? {{24{lane[7] & ~funct3[2]}}, lane[7:0]} :
            sz == 3'd2 ? {{16{lane[15] & ~funct3[2]}}, lane[15:0]} : lane;
    mdata = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one load/store per handshake onto a word-wide memory, with read-modify-write for SB/SH
//   req_*        : MEM-stage request handshake and payload
//   rsp_valid    : access complete pulse, rsp_rdata carries the extended load data
//   misalign_err : rejected-access pulse
//   mem_*        : word-wide memory port with one-cycle registered read
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  misalign_err,
  output logic [DM_ADDRESS-1:0] mem_raddr,
  output logic [DM_ADDRESS-1:0] mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_wr,
  input  logic [DATA_W-1:0]     mem_rdata
);
  dmem_state_e state;
  logic [2:0] f3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ldata, mdata;
  logic idle;
  assign idle = state == IDLE;
  assign req_ready = idle;
  // The read is launched in the accept cycle so the word is ready in the following state.
  assign mem_raddr = {idle ? req_addr[DM_ADDRESS-1:2] : addr_q[DM_ADDRESS-1:2], 2'b00};
  dmem_lane_align u_align (
    .word(mem_rdata),
    .wdata(wdata_q),
    .off(addr_q[1:0]),
    .funct3(f3_q),
    .ldata(ldata),
    .mdata(mdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      misalign_err <= 1'b0;
      mem_wr <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      misalign_err <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          f3_q <= req_funct3;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          if (misaligned(req_funct3, req_addr[1:0])) misalign_err <= 1'b1;
          else if (!req_we) state <= LOAD_WAIT;
          else if (lane_size(req_funct3) == 3'd4) begin
            state <= SW_WRITE;
            mem_wr <= 1'b1;
            mem_waddr <= {req_addr[DM_ADDRESS-1:2], 2'b00};
            mem_wdata <= req_wdata;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end else state <= RMW_READ;
        end
        LOAD_WAIT: begin
          state <= IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= ldata;
        end
        RMW_READ: begin
          state <= RMW_WRITE;
          mem_wr <= 1'b1;
          mem_waddr <= {addr_q[DM_ADDRESS-1:2], 2'b00};
          mem_wdata <= mdata;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
